// File: rtl/dual_edge_pkg.sv
// Shared definitions for the dual-edge XOR pipeline: channel mode encoding
// and the saturating increment used by the valid-beat counter.
package dual_edge_pkg;

    typedef enum logic [1:0] {
        MODE_P    = 2'b00,
        MODE_N    = 2'b01,
        MODE_X    = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Counters up to 32 bits are passed zero-extended; max is the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt == max) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/dual_edge_cell.sv
// One channel of the mixed-edge XOR cell: posedge P, negedge N cross-feeding
// each other, plus the mode mux that loads the first pipeline stage.
module dual_edge_cell
    import dual_edge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] stage0
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] stage0_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p <= '0;
        else        p <= d ^ n;
    end

    // The falling-edge half of the loop; d is sampled again here.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) n <= '0;
        else        n <= d ^ p;
    end

    always_comb begin
        stage0_nxt = stage0;
        case (mode_e'(sel))
            MODE_P:    stage0_nxt = p;
            MODE_N:    stage0_nxt = n;
            MODE_X:    stage0_nxt = p ^ n;
            MODE_HOLD: stage0_nxt = stage0;
            default:   stage0_nxt = stage0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage0 <= '0;
        else        stage0 <= stage0_nxt;
    end

endmodule

// File: rtl/dual_edge_pipe.sv
// Multi-channel dual-edge XOR pipeline: CH cells feed a DEPTH-stage posedge
// pipeline, with a parallel valid chain and a saturating beat counter.
module dual_edge_pipe
    import dual_edge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] d,
    input  logic [CH*2-1:0]     sel,
    input  logic                in_valid,
    input  logic                clr_cnt,
    output logic [CH*WIDTH-1:0] q,
    output logic                out_valid,
    output logic [CNT_W-1:0]    vld_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH*WIDTH-1:0] s0;
    logic                v_p;
    logic [DEPTH-1:0]    v_s;

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_cell
            dual_edge_cell #(.WIDTH(WIDTH)) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .d      (d[c*WIDTH +: WIDTH]),
                .sel    (sel[c*2 +: 2]),
                .stage0 (s0[c*WIDTH +: WIDTH])
            );
        end

        if (DEPTH == 1) begin : g_direct
            assign q = s0;
        end else begin : g_pipe
            logic [CH*WIDTH-1:0] stg [DEPTH-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH-1; i++) stg[i] <= '0;
                end else begin
                    stg[0] <= s0;
                    for (int i = 1; i < DEPTH-1; i++) stg[i] <= stg[i-1];
                end
            end

            assign q = stg[DEPTH-2];
        end
    endgenerate

    // v_p sits alongside P; v_s[i] alongside pipeline stage i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_p <= 1'b0;
            v_s <= '0;
        end else begin
            v_p    <= in_valid;
            v_s[0] <= v_p;
            for (int i = 1; i < DEPTH; i++) v_s[i] <= v_s[i-1];
        end
    end

    assign out_valid = v_s[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         vld_cnt <= '0;
        else if (clr_cnt)   vld_cnt <= '0;
        else if (out_valid) vld_cnt <= CNT_W'(sat_inc(32'(vld_cnt), 32'(CNT_MAX)));
    end

endmodule
